// File: rtl/decode_stage_if.sv
// Fetch/decode/writeback/execute signal bundle for the RV32I decode stage.
// The decode stage connects through the slave modport; the driving side uses master.
`ifndef WORD
`define WORD 32
`endif

interface decode_stage_if #(parameter int REG_POWER = 5);
  logic [`WORD-1:0]   pcD;
  logic [`WORD-1:0]   instrD;
  logic               validD;
  logic               stallD;
  logic               flushE;
  logic               RegWriteW;
  logic [REG_POWER-1:0] rdW;
  logic [`WORD-1:0]   resultW;
  logic [REG_POWER-1:0] rs1D;
  logic [REG_POWER-1:0] rs2D;
  logic [`WORD-1:0]   pcE;
  logic [`WORD-1:0]   rs1valE;
  logic [`WORD-1:0]   rs2valE;
  logic [`WORD-1:0]   immE;
  logic [REG_POWER-1:0] rs1E;
  logic [REG_POWER-1:0] rs2E;
  logic [REG_POWER-1:0] rdE;
  logic [6:0]         opcodeE;
  logic [2:0]         funct3E;
  logic [6:0]         funct7E;
  logic               illegalE;
  logic               validE;

  modport master (
    output pcD, instrD, validD, stallD, flushE, RegWriteW, rdW, resultW,
    input  rs1D, rs2D, pcE, rs1valE, rs2valE, immE, rs1E, rs2E, rdE,
           opcodeE, funct3E, funct7E, illegalE, validE
  );

  modport slave (
    input  pcD, instrD, validD, stallD, flushE, RegWriteW, rdW, resultW,
    output rs1D, rs2D, pcE, rs1valE, rs2valE, immE, rs1E, rs2E, rdE,
           opcodeE, funct3E, funct7E, illegalE, validE
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, field/immediate decode and the decode->execute register.
// Define DECODE_WB_BYPASS_EN for write-first forwarding from writeback into the operand reads.
`ifndef WORD
`define WORD 32
`endif

module decode_stage #(
  parameter int               REG_POWER = 5,
  parameter logic [`WORD-1:0] RESET_PC  = '0
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);
  localparam int REGS = 1 << REG_POWER;

  typedef struct packed {
    logic [`WORD-1:0]     pc;
    logic [`WORD-1:0]     rs1val;
    logic [`WORD-1:0]     rs2val;
    logic [`WORD-1:0]     imm;
    logic [REG_POWER-1:0] rs1;
    logic [REG_POWER-1:0] rs2;
    logic [REG_POWER-1:0] rd;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 illegal;
    logic                 valid;
  } de_t;

  localparam int  FW     = $bits(de_t);
  // pc is the most significant field, so the bubble is RESET_PC followed by zeros
  localparam de_t BUBBLE = de_t'({RESET_PC, {(FW - `WORD){1'b0}}});

  logic [`WORD-1:0]     rf [REGS];
  logic [REG_POWER-1:0] rs1;
  logic [REG_POWER-1:0] rs2;
  logic [`WORD-1:0]     rs1val;
  logic [`WORD-1:0]     rs2val;
  logic [`WORD-1:0]     imm;
  logic                 illegal;
  de_t                  dec;
  de_t                  pipe;

  assign rs1      = REG_POWER'(bus.instrD[19:15]);
  assign rs2      = REG_POWER'(bus.instrD[24:20]);
  assign bus.rs1D = rs1;
  assign bus.rs2D = rs2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
    end else if (bus.RegWriteW && bus.rdW != '0) begin
      rf[bus.rdW] <= bus.resultW;
    end
  end

  always_comb begin
    rs1val = (rs1 == '0) ? '0 : rf[rs1];
    rs2val = (rs2 == '0) ? '0 : rf[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (bus.RegWriteW && bus.rdW != '0 && bus.rdW == rs1) rs1val = bus.resultW;
    if (bus.RegWriteW && bus.rdW != '0 && bus.rdW == rs2) rs2val = bus.resultW;
`endif
  end

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (bus.instrD[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        imm = {{20{bus.instrD[31]}}, bus.instrD[31:20]};
      7'b0100011:
        imm = {{20{bus.instrD[31]}}, bus.instrD[31:25], bus.instrD[11:7]};
      7'b1100011:
        imm = {{19{bus.instrD[31]}}, bus.instrD[31], bus.instrD[7],
               bus.instrD[30:25], bus.instrD[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {bus.instrD[31:12], 12'b0};
      7'b1101111:
        imm = {{11{bus.instrD[31]}}, bus.instrD[31], bus.instrD[19:12],
               bus.instrD[20], bus.instrD[30:21], 1'b0};
      7'b0110011:
        imm = '0;
      default:
        illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = bus.pcD;
    dec.rs1val  = rs1val;
    dec.rs2val  = rs2val;
    dec.imm     = imm;
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.rd      = REG_POWER'(bus.instrD[11:7]);
    dec.opcode  = bus.instrD[6:0];
    dec.funct3  = bus.instrD[14:12];
    dec.funct7  = bus.instrD[31:25];
    dec.illegal = illegal;
    dec.valid   = 1'b1;
  end

  // Flush beats stall; an unstalled bubble from fetch is treated like a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe <= BUBBLE;
    end else if (bus.flushE || (!bus.stallD && !bus.validD)) begin
      pipe <= BUBBLE;
    end else if (!bus.stallD) begin
      pipe <= dec;
    end
  end

  assign bus.pcE      = pipe.pc;
  assign bus.rs1valE  = pipe.rs1val;
  assign bus.rs2valE  = pipe.rs2val;
  assign bus.immE     = pipe.imm;
  assign bus.rs1E     = pipe.rs1;
  assign bus.rs2E     = pipe.rs2;
  assign bus.rdE      = pipe.rd;
  assign bus.opcodeE  = pipe.opcode;
  assign bus.funct3E  = pipe.funct3;
  assign bus.funct7E  = pipe.funct7;
  assign bus.illegalE = pipe.illegal;
  assign bus.validE   = pipe.valid;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared against an arithmetic model of the register file and decode rules.
module tb_decode_stage;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.REG_POWER(5)) bus ();
  decode_stage #(.REG_POWER(5), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [31:0] mrf [32];
  logic [31:0] e_pc, e_rs1v, e_rs2v, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [6:0]  e_op, e_f7;
  logic [2:0]  e_f3;
  logic        e_ill, e_valid;

  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};

  function automatic bit is_legal(logic [6:0] op);
    return op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
  endfunction

  // immediates rebuilt with signed shifts instead of bit concatenation
  function automatic logic [31:0] ref_imm(logic [31:0] ins);
    int s;
    s = $signed(ins);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 32'(s >>> 20);
      7'h23: return 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
      7'h63: return 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) |
                    (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      7'h6F: return 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) |
                    (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(logic [4:0] idx, bit we, logic [4:0] rd, logic [31:0] res);
    logic [31:0] v;
    v = (idx == 5'd0) ? 32'h0 : mrf[idx];
`ifdef DECODE_WB_BYPASS_EN
    if (we && rd != 5'd0 && rd == idx) v = res;
`endif
    return v;
  endfunction

  task automatic model_bubble();
    e_pc = 32'h0; e_rs1v = '0; e_rs2v = '0; e_imm = '0;
    e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_op = '0; e_f3 = '0; e_f7 = '0;
    e_ill = 1'b0; e_valid = 1'b0;
  endtask

  // drive one cycle of inputs, advance the model at the rising edge, return at the falling edge
  task automatic step(logic [31:0] pc, logic [31:0] ins, bit valid, bit stall, bit flush,
                      bit we, logic [4:0] rd, logic [31:0] res);
    bus.pcD = pc; bus.instrD = ins; bus.validD = valid; bus.stallD = stall;
    bus.flushE = flush; bus.RegWriteW = we; bus.rdW = rd; bus.resultW = res;
    @(posedge clk);
    if (flush || (!stall && !valid)) begin
      model_bubble();
    end else if (!stall) begin
      e_pc = pc; e_rs1 = ins[19:15]; e_rs2 = ins[24:20]; e_rd = ins[11:7];
      e_rs1v = ref_read(ins[19:15], we, rd, res);
      e_rs2v = ref_read(ins[24:20], we, rd, res);
      e_op = ins[6:0]; e_f3 = ins[14:12]; e_f7 = ins[31:25];
      e_ill = !is_legal(ins[6:0]);
      e_imm = e_ill ? 32'h0 : ref_imm(ins);
      e_valid = 1'b1;
    end
    if (we && rd != 5'd0) mrf[rd] = res;
    @(negedge clk);
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    r = $urandom;
    bus.pcD = r; bus.instrD = $urandom; bus.validD = 1'b1; bus.stallD = 1'b0;
    bus.flushE = 1'b0; bus.RegWriteW = 1'b1; bus.rdW = r[4:0]; bus.resultW = $urandom;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    model_bubble();
    total++;
    if ({bus.validE, bus.pcE, bus.immE, bus.illegalE} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got valid=%0b pc=%h imm=%h ill=%0b, want 0/0/0/0",
               bus.validE, bus.pcE, bus.immE, bus.illegalE);
    end
    reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      step(32'h0, (32'(i) << 20) | (32'(i) << 15) | 32'h33, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      total++;
      if ({bus.rs1valE, bus.rs2valE} !== 64'h0) begin
        bad++;
        $display("[TB] FAIL reset_rf_x%0d: got %h/%h, want 0/0", i, bus.rs1valE, bus.rs2valE);
      end
    end
  endtask

  task automatic test_writeback_read();
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step(32'h10, 32'h0052_8293, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++;
    if ({bus.rs1valE, bus.immE, bus.rdE, bus.pcE, bus.validE, bus.illegalE} !==
        {32'hDEAD_BEEF, 32'h5, 5'd5, 32'h10, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL wb_read: got rs1v=%h imm=%h rd=%0d pc=%h v=%0b ill=%0b, want deadbeef/5/5/10/1/0",
               bus.rs1valE, bus.immE, bus.rdE, bus.pcE, bus.validE, bus.illegalE);
    end
  endtask

  task automatic test_x0();
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(32'h14, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++;
    if ({bus.rs1valE, bus.rs2valE} !== 64'h0) begin
      bad++;
      $display("[TB] FAIL x0_write: got %h/%h, want 0/0", bus.rs1valE, bus.rs2valE);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] ins  [3] = '{32'hFE00_0EE3, 32'h1234_50B7, 32'h0000_006F};
    logic [31:0] want [3] = '{32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      step(32'h100 + 32'(i * 4), ins[i], 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      total++;
      if (bus.immE !== want[i] || bus.validE !== 1'b1) begin
        bad++;
        $display("[TB] FAIL imm_%h: got imm=%h v=%0b, want %h v=1", ins[i], bus.immE, bus.validE, want[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    step(32'h20, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++;
    if (bus.pcE !== 32'h20) begin
      bad++;
      $display("[TB] FAIL stall_load: got pc=%h, want 20", bus.pcE);
    end
    for (int i = 0; i < 2; i++) begin
      step(32'h24, 32'h0010_0093, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      total++;
      if (bus.pcE !== 32'h20 || bus.validE !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall_hold_%0d: got pc=%h v=%0b, want 20 v=1", i, bus.pcE, bus.validE);
      end
    end
    step(32'h28, 32'h0010_0093, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    total++;
    if (bus.validE !== 1'b0 || bus.pcE !== 32'h0 || bus.rdE !== 5'd0) begin
      bad++;
      $display("[TB] FAIL stall_flush: got v=%0b pc=%h rd=%0d, want 0/0/0", bus.validE, bus.pcE, bus.rdE);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
`ifdef DECODE_WB_BYPASS_EN
    want = 32'h7;
`else
    want = 32'h0;
`endif
    step(32'h30, 32'h0001_8093, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h7);
    total++;
    if (bus.rs1valE !== want) begin
      bad++;
      $display("[TB] FAIL bypass_same_cycle: got %h, want %h", bus.rs1valE, want);
    end
    step(32'h34, 32'h0001_8093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++;
    if (bus.rs1valE !== 32'h7) begin
      bad++;
      $display("[TB] FAIL bypass_after: got %h, want 7", bus.rs1valE);
    end
  endtask

  task automatic test_illegal();
    step(32'h38, 32'h0000_007F, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    total++;
    if ({bus.illegalE, bus.validE, bus.immE} !== {1'b1, 1'b1, 32'h0}) begin
      bad++;
      $display("[TB] FAIL illegal: got ill=%0b v=%0b imm=%h, want 1/1/0", bus.illegalE, bus.validE, bus.immE);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, ins;
    for (int n = 0; n < 400; n++) begin
      r   = $urandom;
      ins = {r[31:7], ops[$urandom_range(0, 11)]};
      step($urandom, ins, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 31)), $urandom);
      total++;
      if ({bus.rs1D, bus.rs2D} !== {ins[19:15], ins[24:20]}) begin
        bad++;
        $display("[TB] FAIL rand_rsD_%0d: got %0d/%0d, want %0d/%0d", n, bus.rs1D, bus.rs2D, ins[19:15], ins[24:20]);
      end
      total++;
      if ({bus.pcE, bus.rs1valE, bus.rs2valE, bus.immE, bus.rs1E, bus.rs2E, bus.rdE,
           bus.opcodeE, bus.funct3E, bus.funct7E, bus.illegalE, bus.validE} !==
          {e_pc, e_rs1v, e_rs2v, e_imm, e_rs1, e_rs2, e_rd, e_op, e_f3, e_f7, e_ill, e_valid}) begin
        bad++;
        $display("[TB] FAIL rand_cycle_%0d: got pc=%h a=%h b=%h imm=%h rs=%0d/%0d rd=%0d op=%h f3=%0d f7=%h ill=%0b v=%0b; want pc=%h a=%h b=%h imm=%h rs=%0d/%0d rd=%0d op=%h f3=%0d f7=%h ill=%0b v=%0b",
                 n, bus.pcE, bus.rs1valE, bus.rs2valE, bus.immE, bus.rs1E, bus.rs2E, bus.rdE,
                 bus.opcodeE, bus.funct3E, bus.funct7E, bus.illegalE, bus.validE,
                 e_pc, e_rs1v, e_rs2v, e_imm, e_rs1, e_rs2, e_rd, e_op, e_f3, e_f7, e_ill, e_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_writeback_read();
    test_x0();
    test_immediates();
    test_stall_flush();
    test_bypass();
    test_illegal();
    test_random();
    idle();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the fetch→decode interface; takes pcD/instrD/validD from the fetch register.
- Holds the architectural register file: 32 entries × `WORD, x0 hardwired to zero. The write port is driven by writeback.
- Decodes RV32I fields and generates immediates.
- Registers everything into the decode→execute pipeline register, with stall and flush control from the hazard unit.

Parameters:
- REG_POWER, 5, log2 of the register count; the file holds 1<<REG_POWER entries.
- RESET_PC, 0, value loaded into pcE on reset and on flush.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pcD  input  `WORD  PC of the instruction in decode.
- instrD  input  `WORD  raw instruction word.
- validD  input  1  instruction in decode is real (not a bubble).
- stallD  input  1  hold the pipeline register; ignore the new decode input.
- flushE  input  1  load a bubble into the pipeline register.
- RegWriteW  input  1  writeback write enable.
- rdW  input  REG_POWER  writeback destination register.
- resultW  input  `WORD  writeback data.
- rs1D  output  REG_POWER  instrD[19:15], combinational, for the hazard unit.
- rs2D  output  REG_POWER  instrD[24:20], combinational.
- pcE  output  `WORD  registered PC.
- rs1valE  output  `WORD  registered rs1 operand.
- rs2valE  output  `WORD  registered rs2 operand.
- immE  output  `WORD  registered sign-extended immediate.
- rs1E  output  REG_POWER  registered source index 1.
- rs2E  output  REG_POWER  registered source index 2.
- rdE  output  REG_POWER  registered destination index.
- opcodeE  output  7  registered instr[6:0].
- funct3E  output  3  registered instr[14:12].
- funct7E  output  7  registered instr[31:25].
- illegalE  output  1  opcode not in the supported set.
- validE  output  1  registered valid.

Behaviour:
- Reset (reset=0, async): all registered outputs go to 0, except pcE=RESET_PC. All register-file entries clear to 0.
- Register file write: on the rising edge when RegWriteW=1 and rdW≠0, RAM[rdW] takes resultW. Writes to x0 are dropped.
- Register file read: combinational. An index of 0 always reads 0.
- Decode latency: 1 cycle. Decode inputs at edge N appear on the *E outputs after edge N.
- Pipeline register priority, highest first:
  - reset.
  - flushE=1: bubble. validE=0, illegalE=0, pcE=RESET_PC, all other fields 0.
  - stallD=1: all *E outputs hold their values.
  - otherwise: load the decoded values.
- flushE and stallD asserted together → flush wins.
- A register-file write still occurs during stall and during flush.
- validD=0 (not stalled, not flushed) → behaves as a flush: bubble loaded.
- Immediate by opcode (instr[6:0]), sign-extended from instr[31]:
  - I-type: 0010011, 0000011, 1100111, 1110011 → {instr[31:20]}.
  - S-type: 0100011 → {instr[31:25], instr[11:7]}.
  - B-type: 1100011 → {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: 0110111, 0010111 → {instr[31:12], 12'b0}.
  - J-type: 1101111 → {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: 0110011 → 0.
  - Any other opcode → immE=0, illegalE=1, validE still follows validD.
- rdE, rs1E, rs2E are taken from their instruction fields regardless of format. The execute stage qualifies them by opcode.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: write-first bypass on register-file reads. If RegWriteW=1, rdW≠0 and rdW equals the rs1 (or rs2) index, that operand uses resultW in the same cycle.
- Not defined: no bypass. An operand read in the same cycle as a write to that register captures the old value. The hazard unit must then stall one cycle for a WB→D dependency.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs → validE=0, pcE=0, immE=0; reading x1..x31 after release gives 0.
- Writeback then read: RegWriteW=1, rdW=5, resultW=0xDEADBEEF for one cycle. Next cycle instrD=0x00528293 (addi x5,x5,5), validD=1, pcD=0x10. Next edge → rs1valE=0xDEADBEEF, immE=5, rdE=5, pcE=0x10, validE=1, illegalE=0.
- x0 protection: write rdW=0, resultW=0xFFFFFFFF, then decode instrD=0x00000033 (add x0,x0,x0) → rs1valE=0, rs2valE=0.
- Immediates:
  - instrD=0xFE000EE3 (B, offset −4) → immE=0xFFFFFFFC.
  - instrD=0x123450B7 (lui) → immE=0x12345000.
  - instrD=0x0000006F (jal 0) → immE=0.
- Stall/flush:
  - Load pcD=0x20 valid, then stallD=1 with pcD=0x24 for 2 cycles → pcE stays 0x20.
  - Then stallD=1 and flushE=1 together → validE=0, pcE=0.
- Bypass: same-cycle write rdW=3, resultW=7 while decoding a read of x3 → rs1valE=7 with DECODE_WB_BYPASS_EN defined, the old value (0) without it. Illegal opcode instrD=0x0000007F → illegalE=1.
